// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: turns single-beat user read/write commands into AXI-Lite
// transactions, one in flight, and hands back exactly one response per command.
module axi_lite_master #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STROBE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   i_cmd_data,
  input  logic [STROBE_WIDTH-1:0] i_cmd_strb,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic                    o_rsp_write,
  output logic [1:0]              o_rsp_resp,
  output logic [DATA_WIDTH-1:0]   o_rsp_data,
  output logic                    o_awvalid,
  input  logic                    i_awready,
  output logic [ADDR_WIDTH-1:0]   o_awaddr,
  output logic                    o_wvalid,
  input  logic                    i_wready,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [STROBE_WIDTH-1:0] o_wstrb,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  input  logic [1:0]              i_bresp,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  output logic [ADDR_WIDTH-1:0]   o_araddr,
  input  logic                    i_rvalid,
  output logic                    o_rready,
  input  logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic [1:0]              i_rresp,
  output logic [2:0]              o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high. Valids never look at ready, and once raised stay up with a stable payload
  // until that transfer; readies are raised only in the state that consumes them.

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    RSP_HOLD     = 3'd5
  } state_t;

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   aw_hs;
  logic   w_hs;
  logic   aw_fin;
  logic   w_fin;
  logic   state_legal;

  assign o_dbg_state = state;

  always_comb begin
    aw_hs  = o_awvalid && i_awready;
    w_hs   = o_wvalid && i_wready;
    aw_fin = aw_done || aw_hs;
    w_fin  = w_done || w_hs;
    case (state)
      IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP_HOLD: state_legal = 1'b1;
      default:                                                 state_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !state_legal) begin
      state       <= IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      o_cmd_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_write <= 1'b0;
      o_rsp_resp  <= 2'b00;
      o_rsp_data  <= '0;
      o_awvalid   <= 1'b0;
      o_awaddr    <= '0;
      o_wvalid    <= 1'b0;
      o_wdata     <= '0;
      o_wstrb     <= '0;
      o_bready    <= 1'b0;
      o_arvalid   <= 1'b0;
      o_araddr    <= '0;
      o_rready    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_cmd_valid && o_cmd_ready) begin
            o_cmd_ready <= 1'b0;
            if (i_cmd_write) begin
              o_awaddr  <= i_cmd_addr;
              o_wdata   <= i_cmd_data;
              o_wstrb   <= i_cmd_strb;
              o_awvalid <= 1'b1;
              o_wvalid  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
              state     <= WR_ADDR_DATA;
            end else begin
              o_araddr  <= i_cmd_addr;
              o_arvalid <= 1'b1;
              state     <= RD_ADDR;
            end
          end
        end
        WR_ADDR_DATA: begin
          // AW and W complete independently, in either order or together.
          if (aw_hs) o_awvalid <= 1'b0;
          if (w_hs)  o_wvalid  <= 1'b0;
          if (aw_fin && w_fin) begin
            o_bready <= 1'b1;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            state    <= WR_RESP;
          end else begin
            aw_done <= aw_fin;
            w_done  <= w_fin;
          end
        end
        WR_RESP: begin
          if (i_bvalid && o_bready) begin
            o_bready    <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_write <= 1'b1;
            o_rsp_resp  <= i_bresp;
            o_rsp_data  <= '0;
            state       <= RSP_HOLD;
          end
        end
        RD_ADDR: begin
          if (o_arvalid && i_arready) begin
            o_arvalid <= 1'b0;
            o_rready  <= 1'b1;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (i_rvalid && o_rready) begin
            o_rready    <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_write <= 1'b0;
            o_rsp_data  <= i_rdata;
            o_rsp_resp  <= i_rresp;
            state       <= RSP_HOLD;
          end
        end
        RSP_HOLD: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: an in-bench AXI-Lite slave with programmable waits,
// a transaction-level model of what the master must show each cycle, and directed tests.
module tb_axi_lite_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int EW = DW + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [SW-1:0] cmd_strb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [1:0]    rsp_resp;
  logic [DW-1:0] rsp_data;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;
  logic [2:0]    dbg_state;

  axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STROBE_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data), .i_cmd_strb(cmd_strb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_write(rsp_write),
    .o_rsp_resp(rsp_resp), .o_rsp_data(rsp_data),
    .o_awvalid(awvalid), .i_awready(awready), .o_awaddr(awaddr),
    .o_wvalid(wvalid), .i_wready(wready), .o_wdata(wdata), .o_wstrb(wstrb),
    .i_bvalid(bvalid), .o_bready(bready), .i_bresp(bresp),
    .o_arvalid(arvalid), .i_arready(arready), .o_araddr(araddr),
    .i_rvalid(rvalid), .o_rready(rready), .i_rdata(rdata), .i_rresp(rresp),
    .o_dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string what);
    n_cmp++;
    n_fail++;
    $display("FAIL timeout_%s: expected DUT event never arrived", what);
  endtask

  // ---------------- slave configuration ----------------
  int          cfg_aw_wait = 0, cfg_w_wait = 0, cfg_b_wait = 0, cfg_ar_wait = 0, cfg_r_wait = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [DW-1:0] cfg_rdata = '0;
  logic        stray = 1'b0;

  // ---------------- transaction-level model ----------------
  int   cyc = 0;
  int   cmd_n = 0, rsp_n = 0, aw_n = 0, w_n = 0, ar_n = 0;
  int   acc_cyc = 0, rsp_cyc = 0;
  logic busy = 1'b0, cur_write = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_data = '0;
  logic [SW-1:0] cur_strb = '0;
  logic aw_done = 1'b0, w_done = 1'b0, b_done = 1'b0, ar_done = 1'b0, r_done = 1'b0;
  logic [EW-1:0] exp_q[$];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      busy = 1'b0;
      {aw_done, w_done, b_done, ar_done, r_done} = '0;
      exp_q.delete();
    end else if (busy) begin
      if (awvalid && awready) begin aw_done = 1'b1; aw_n++; end
      if (wvalid && wready)   begin w_done = 1'b1;  w_n++;  end
      if (arvalid && arready) begin ar_done = 1'b1; ar_n++; end
      if (bvalid && bready)   b_done = 1'b1;
      if (rvalid && rready)   r_done = 1'b1;
      if (rsp_valid && rsp_ready) begin
        busy = 1'b0;
        rsp_n++;
        rsp_cyc = cyc;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end else if (cmd_valid && cmd_ready) begin
      busy = 1'b1;
      cmd_n++;
      acc_cyc = cyc;
      cur_write = cmd_write;
      cur_addr = cmd_addr;
      cur_data = cmd_data;
      cur_strb = cmd_strb;
      {aw_done, w_done, b_done, ar_done, r_done} = '0;
      if (cmd_write) exp_q.push_back({1'b1, cfg_bresp, {DW{1'b0}}});
      else           exp_q.push_back({1'b0, cfg_rresp, cfg_rdata});
    end
  end

  // ---------------- slave responder ----------------
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  initial begin
    {awready, wready, arready, bvalid, rvalid} = '0;
    bresp = 2'b00; rresp = 2'b00; rdata = '0;
    forever begin
      @(negedge clk);
      awready = 1'b0;
      if (awvalid) begin if (aw_cnt >= cfg_aw_wait) awready = 1'b1; else aw_cnt++; end
      else aw_cnt = 0;
      wready = 1'b0;
      if (wvalid) begin if (w_cnt >= cfg_w_wait) wready = 1'b1; else w_cnt++; end
      else w_cnt = 0;
      arready = 1'b0;
      if (arvalid) begin if (ar_cnt >= cfg_ar_wait) arready = 1'b1; else ar_cnt++; end
      else ar_cnt = 0;
      // B/R are offered once the address (and data) phase has completed.
      bvalid = stray;
      if (busy && cur_write && aw_done && w_done && !b_done) begin
        if (b_cnt >= cfg_b_wait) bvalid = 1'b1; else b_cnt++;
      end else b_cnt = 0;
      rvalid = stray;
      if (busy && !cur_write && ar_done && !r_done) begin
        if (r_cnt >= cfg_r_wait) rvalid = 1'b1; else r_cnt++;
      end else r_cnt = 0;
      bresp = bvalid ? cfg_bresp : ~cfg_bresp;
      rresp = rvalid ? cfg_rresp : ~cfg_rresp;
      rdata = rvalid ? cfg_rdata : ~cfg_rdata;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  int   first_aw = -1, first_ar = -1, first_bready = -1, first_rready = -1, first_rsp = -1;
  logic saw_aw_first = 1'b0, saw_w_first = 1'b0;

  always @(negedge clk) begin
    if (check_en) begin
      chk("cmd_ready", cmd_ready, !busy);
      chk("awvalid", awvalid, busy && cur_write && !aw_done);
      chk("wvalid", wvalid, busy && cur_write && !w_done);
      chk("bready", bready, busy && cur_write && aw_done && w_done && !b_done);
      chk("arvalid", arvalid, busy && !cur_write && !ar_done);
      chk("rready", rready, busy && !cur_write && ar_done && !r_done);
      chk("rsp_valid", rsp_valid, busy && (cur_write ? b_done : r_done));
      if (awvalid) chk("awaddr", awaddr, cur_addr);
      if (wvalid) begin
        chk("wdata", wdata, cur_data);
        chk("wstrb", wstrb, cur_strb);
      end
      if (arvalid) chk("araddr", araddr, cur_addr);
      if (rsp_valid && exp_q.size() > 0) chk("rsp_fields", {rsp_write, rsp_resp, rsp_data}, exp_q[0]);
      if (awvalid && first_aw < 0) first_aw = cyc;
      if (arvalid && first_ar < 0) first_ar = cyc;
      if (bready && first_bready < 0) first_bready = cyc;
      if (rready && first_rready < 0) first_rready = cyc;
      if (rsp_valid && first_rsp < 0) first_rsp = cyc;
      if (busy && aw_done && wvalid) saw_aw_first = 1'b1;
      if (busy && w_done && awvalid) saw_w_first = 1'b1;
    end
  end

  // latency in cycles from the accept cycle T
  function automatic int lat(input int c);
    return c - acc_cyc + 1;
  endfunction

  // ---------------- driver tasks ----------------
  logic          got_write;
  logic [1:0]    got_resp;
  logic [DW-1:0] got_data;

  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s);
    int start, k;
    first_aw = -1; first_ar = -1; first_bready = -1; first_rready = -1; first_rsp = -1;
    saw_aw_first = 1'b0; saw_w_first = 1'b0;
    start = cmd_n;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = d; cmd_strb = s;
    k = 0;
    while (cmd_n == start && k < 50) begin @(negedge clk); k++; end
    cmd_valid = 1'b0;
    cmd_addr = $urandom();
    cmd_data = $urandom();
    cmd_strb = SW'($urandom_range(0, 15));
    if (cmd_n == start) tmo("accept");
  endtask

  task automatic collect(input int hold, input logic nx_en, input logic nx_wr,
                         input logic [AW-1:0] nx_a);
    int start, k;
    k = 0;
    while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
    if (!rsp_valid) begin tmo("rsp"); return; end
    got_write = rsp_write; got_resp = rsp_resp; got_data = rsp_data;
    if (nx_en) begin
      cmd_valid = 1'b1; cmd_write = nx_wr; cmd_addr = nx_a; cmd_data = '0; cmd_strb = '0;
    end
    repeat (hold) @(negedge clk);
    start = rsp_n;
    rsp_ready = 1'b1;
    k = 0;
    while (rsp_n == start && k < 10) begin @(negedge clk); k++; end
    rsp_ready = 1'b0;
    if (rsp_n == start) tmo("rsp_accept");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    chk({tag, "_valids_readies"}, {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'b0);
    chk({tag, "_rsp_fields"}, {rsp_write, rsp_resp, rsp_data}, '0);
    chk({tag, "_payload"}, {awaddr, araddr, wdata, wstrb}, '0);
  endtask

  // ---------------- directed tests ----------------
  int r0, c0, k;
  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_strb = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    check_en = 1'b1;
    @(negedge clk);

    // Write, zero-wait slave: valids T+1, bready T+2, response T+3.
    r0 = aw_n; c0 = w_n;
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    collect(0, 1'b0, 1'b0, '0);
    chk("t1_aw_lat", lat(first_aw), 1);
    chk("t1_bready_lat", lat(first_bready), 2);
    chk("t1_rsp_lat", lat(first_rsp), 3);
    chk("t1_aw_w_once", {aw_n - r0, w_n - c0}, {32'd1, 32'd1});
    chk("t1_rsp", {got_write, got_resp, got_data}, {1'b1, 2'b00, 32'h0});

    // Read with three wait cycles on AR and on R.
    cfg_ar_wait = 3; cfg_r_wait = 3; cfg_rdata = 32'h12345678; cfg_rresp = 2'b00;
    send(1'b0, 32'h20, 32'h0, 4'h0);
    collect(0, 1'b0, 1'b0, '0);
    chk("t2_rready_lat", lat(first_rready), 5);
    chk("t2_rsp_lat", lat(first_rsp), 9);
    chk("t2_rsp", {got_write, got_resp, got_data}, {1'b0, 2'b00, 32'h12345678});
    cfg_ar_wait = 0; cfg_r_wait = 0;

    // AW accepted two cycles before W.
    cfg_w_wait = 2;
    send(1'b1, 32'h18, 32'h01020304, 4'h5);
    collect(1, 1'b0, 1'b0, '0);
    chk("t3_aw_first", saw_aw_first, 1'b1);
    chk("t3_bready_lat", lat(first_bready), 4);
    chk("t3_rsp", {got_write, got_resp, got_data}, {1'b1, 2'b00, 32'h0});
    cfg_w_wait = 0;

    // W accepted before AW, slave error on B.
    cfg_aw_wait = 3; cfg_bresp = 2'b10;
    send(1'b1, 32'h14, 32'h0000A5A5, 4'h3);
    collect(0, 1'b0, 1'b0, '0);
    chk("t3b_w_first", saw_w_first, 1'b1);
    chk("t3b_bready_lat", lat(first_bready), 5);
    chk("t3b_rsp", {got_write, got_resp, got_data}, {1'b1, 2'b10, 32'h0});
    cfg_aw_wait = 0; cfg_bresp = 2'b00;

    // Read to an unmapped address, DECERR passed through.
    cfg_rresp = 2'b11; cfg_rdata = 32'h0;
    send(1'b0, 32'hFFC, 32'h0, 4'h0);
    collect(0, 1'b0, 1'b0, '0);
    chk("t4_rsp", {got_write, got_resp, got_data}, {1'b0, 2'b11, 32'h0});
    cfg_rresp = 2'b00;

    // Stray B/R valids while idle are ignored.
    r0 = rsp_n; stray = 1'b1;
    repeat (4) @(negedge clk);
    stray = 1'b0;
    chk("stray_no_rsp", rsp_n - r0, 0);
    chk("stray_idle", {rsp_valid, cmd_ready}, 2'b01);

    // Response held for 5 cycles with a new command already waiting.
    cfg_b_wait = 1; cfg_rdata = 32'h55667788;
    c0 = cmd_n;
    send(1'b1, 32'h30, 32'h11112222, 4'hC);
    collect(5, 1'b1, 1'b0, 32'h34);
    chk("t5_no_early_accept", cmd_n - c0, 1);
    send(1'b0, 32'h34, 32'h0, 4'h0);
    chk("t5_accept_after_release", acc_cyc - rsp_cyc, 1);
    collect(0, 1'b0, 1'b0, '0);
    chk("t5_rsp", {got_write, got_resp, got_data}, {1'b0, 2'b00, 32'h55667788});
    cfg_b_wait = 0;

    // Reset while waiting for B: everything back to reset values, no response.
    cfg_b_wait = 20;
    r0 = rsp_n;
    send(1'b1, 32'h50, 32'h0BADC0DE, 4'hF);
    k = 0;
    while (!bready && k < 20) begin @(negedge clk); k++; end
    if (!bready) tmo("bready");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("t6_mid_rst");
    cfg_b_wait = 0;
    repeat (3) @(negedge clk);
    chk("t6_no_rsp", {rsp_n - r0, 31'(rsp_valid)}, 0);
    cfg_rdata = 32'hCAFE0001;
    send(1'b0, 32'h44, 32'h0, 4'h0);
    collect(2, 1'b0, 1'b0, '0);
    chk("t6_read_after_rst", {got_write, got_resp, got_data}, {1'b0, 2'b00, 32'hCAFE0001});

    repeat (3) @(negedge clk);
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, compared %0d", n_cmp);
    $fatal(1, "global timeout");
  end

endmodule
